// File: rtl/tmr_tick_prescaler.sv
// rtl/tmr_tick_prescaler.sv - triple-redundant tick prescaler with bitwise majority voting
//
// Purpose: emits a one-cycle tick every div_reg+1 cycles while running. State,
// count and divide register are each held in three replicas. Every replica
// reloads from the voted values, so a single upset heals in one cycle.
//
// Optional feature macro: TMR_PRESCALER_FAULT_CNT_EN (adds fault_cnt).
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   start      begin ticking (honoured in IDLE only)
//   stop       halt ticking (honoured in RUN only)
//   div_valid  new divide value offered
//   div_value  divide value, period = div_value+1 cycles
//   div_ready  divide value accepted this cycle when div_valid is high
//   tick       one-cycle enable pulse
//   running    voted state is RUN
//   fault_cnt  saturating count of mismatch cycles (macro builds only)
//   mismatch   a replica disagreed with the vote in the previous cycle
module tmr_tick_prescaler #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             div_valid,
    input  logic [WIDTH-1:0] div_value,
    output logic             div_ready,
    output logic             tick,
    output logic             running,
`ifdef TMR_PRESCALER_FAULT_CNT_EN
    output logic [7:0]       fault_cnt,
`endif
    output logic             mismatch
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [1:0] vote2(input logic [1:0] a, input logic [1:0] b,
                                         input logic [1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [WIDTH-1:0] vote_w(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [1:0]       state_q0, state_q1, state_q2;
    logic [WIDTH-1:0] cnt_q0, cnt_q1, cnt_q2;
    logic [WIDTH-1:0] div_q0, div_q1, div_q2;

    logic [1:0]       state_raw;
    state_t           state_v;
    state_t           state_nxt;
    logic [WIDTH-1:0] cnt_v, div_v, cnt_nxt, div_nxt;
    logic             period_end;
    logic             mismatch_now;

    assign state_raw  = vote2(state_q0, state_q1, state_q2);
    // Any voted encoding other than RUN (including the unused ones) is IDLE.
    assign state_v    = (state_raw == ST_RUN) ? ST_RUN : ST_IDLE;
    assign cnt_v      = vote_w(cnt_q0, cnt_q1, cnt_q2);
    assign div_v      = vote_w(div_q0, div_q1, div_q2);
    assign period_end = (cnt_v == div_v);

    always_comb begin
        state_nxt = state_v;
        cnt_nxt   = cnt_v;
        div_nxt   = div_v;
        tick      = 1'b0;
        running   = 1'b0;
        div_ready = 1'b1;
        case (state_v)
            ST_RUN: begin
                running = 1'b1;
                // A stop suppresses both the tick and the divide handshake so
                // that div_reg is left untouched while halting.
                tick      = period_end && !stop;
                div_ready = period_end && !stop;
                if (stop) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (period_end) begin
                    cnt_nxt = '0;
                    if (div_valid) begin
                        div_nxt = div_value;
                    end
                end else begin
                    cnt_nxt = cnt_v + ONE;
                end
            end
            default: begin
                cnt_nxt = '0;
                if (div_valid) begin
                    div_nxt = div_value;
                end
                if (start && !stop) begin
                    state_nxt = ST_RUN;
                end
            end
        endcase
    end

`ifdef TMR_PRESCALER_FAULT_CNT_EN
    function automatic logic [7:0] vote8(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [7:0] fc_q0, fc_q1, fc_q2;
    logic [7:0] fc_v, fc_nxt;

    assign fc_v      = vote8(fc_q0, fc_q1, fc_q2);
    assign fc_nxt    = (mismatch && fc_v != 8'hFF) ? fc_v + 8'd1 : fc_v;
    assign fault_cnt = fc_v;

    assign mismatch_now = (state_q0 != state_raw) || (state_q1 != state_raw) ||
                          (state_q2 != state_raw) ||
                          (cnt_q0 != cnt_v) || (cnt_q1 != cnt_v) || (cnt_q2 != cnt_v) ||
                          (div_q0 != div_v) || (div_q1 != div_v) || (div_q2 != div_v) ||
                          (fc_q0 != fc_v) || (fc_q1 != fc_v) || (fc_q2 != fc_v);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fc_q0 <= 8'd0;
            fc_q1 <= 8'd0;
            fc_q2 <= 8'd0;
        end else begin
            fc_q0 <= fc_nxt;
            fc_q1 <= fc_nxt;
            fc_q2 <= fc_nxt;
        end
    end
`else
    assign mismatch_now = (state_q0 != state_raw) || (state_q1 != state_raw) ||
                          (state_q2 != state_raw) ||
                          (cnt_q0 != cnt_v) || (cnt_q1 != cnt_v) || (cnt_q2 != cnt_v) ||
                          (div_q0 != div_v) || (div_q1 != div_v) || (div_q2 != div_v);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q0 <= ST_IDLE;
            state_q1 <= ST_IDLE;
            state_q2 <= ST_IDLE;
            cnt_q0   <= '0;
            cnt_q1   <= '0;
            cnt_q2   <= '0;
            div_q0   <= '0;
            div_q1   <= '0;
            div_q2   <= '0;
            mismatch <= 1'b0;
        end else begin
            state_q0 <= state_nxt;
            state_q1 <= state_nxt;
            state_q2 <= state_nxt;
            cnt_q0   <= cnt_nxt;
            cnt_q1   <= cnt_nxt;
            cnt_q2   <= cnt_nxt;
            div_q0   <= div_nxt;
            div_q1   <= div_nxt;
            div_q2   <= div_nxt;
            mismatch <= mismatch_now;
        end
    end

endmodule

// File: tb/tb_tmr_tick_prescaler.sv
// tb/tb_tmr_tick_prescaler.sv - self-checking bench for tmr_tick_prescaler
module tb_tmr_tick_prescaler;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        div_valid;
    logic [15:0] div_value;
    logic        div_ready;
    logic        tick;
    logic        running;
    logic        mismatch;
`ifdef TMR_PRESCALER_FAULT_CNT_EN
    logic [7:0]  fault_cnt;
`endif

    tmr_tick_prescaler #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .div_valid (div_valid),
        .div_value (div_value),
        .div_ready (div_ready),
        .tick      (tick),
        .running   (running),
`ifdef TMR_PRESCALER_FAULT_CNT_EN
        .fault_cnt (fault_cnt),
`endif
        .mismatch  (mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       tick;
        logic       running;
        logic       ready;
        logic       mismatch;
        logic [7:0] fault;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad = 0;
    int tick_seen = 0;
    bit last_accept = 0;
    bit chk_rep = 0;

    // Reference model
    bit          m_run;
    logic [15:0] m_cnt;
    logic [15:0] m_div;
    bit          m_mis;
    logic [7:0]  m_fault;

    task automatic m_reset();
        m_run   = 0;
        m_cnt   = 16'd0;
        m_div   = 16'd0;
        m_mis   = 0;
        m_fault = 8'd0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic sp);
        exp_t e;
        e.tick     = m_run && (m_cnt == m_div) && !sp;
        e.running  = m_run;
        e.ready    = m_run ? e.tick : 1'b1;
        e.mismatch = m_mis;
        e.fault    = m_fault;
        exp_q.push_back(e);
    endtask

    task automatic check_outputs(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_tick"}, {31'd0, tick}, {31'd0, e.tick});
            chk({tag, "_running"}, {31'd0, running}, {31'd0, e.running});
            chk({tag, "_div_ready"}, {31'd0, div_ready}, {31'd0, e.ready});
            chk({tag, "_mismatch"}, {31'd0, mismatch}, {31'd0, e.mismatch});
`ifdef TMR_PRESCALER_FAULT_CNT_EN
            chk({tag, "_fault_cnt"}, {24'd0, fault_cnt}, {24'd0, e.fault});
`endif
            last_accept = e.ready && div_valid;
        end
    endtask

    task automatic advance(input logic s, input logic sp, input logic dv,
                           input logic [15:0] dval, input bit corrupt);
        if (m_mis && m_fault != 8'hFF) m_fault = m_fault + 8'd1;
        m_mis = corrupt;
        if (!m_run) begin
            if (dv) m_div = dval;
            m_cnt = 16'd0;
            if (s && !sp) m_run = 1;
        end else if (sp) begin
            m_run = 0;
            m_cnt = 16'd0;
        end else if (m_cnt == m_div) begin
            m_cnt = 16'd0;
            if (dv) m_div = dval;
        end else begin
            m_cnt = m_cnt + 16'd1;
        end
    endtask

    task automatic cycle(input string tag, input logic s, input logic sp, input logic dv,
                         input logic [15:0] dval, input bit corrupt);
        @(negedge clk);
        start     = s;
        stop      = sp;
        div_valid = dv;
        div_value = dval;
        if (corrupt) begin
            force dut.cnt_q2 = 16'hFFFF;
            #1;
            release dut.cnt_q2;
        end else begin
            #1;
        end
        push_exp(sp);
        #1;
        check_outputs(tag);
        if (chk_rep) begin
            chk("replica2_resync", {16'd0, dut.cnt_q2}, {16'd0, m_cnt});
            chk_rep = 0;
        end
        if (tick === 1'b1) tick_seen++;
        advance(s, sp, dv, dval, corrupt);
    endtask

    initial begin
        int guard;
        rst       = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        div_valid = 1'b0;
        div_value = 16'd0;
        m_reset();
        #3;
        push_exp(1'b0);
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Load 3 in IDLE, start, expect a tick every 4th cycle.
        cycle("load3", 0, 0, 1, 16'd3, 0);
        cycle("start", 1, 0, 0, 16'd0, 0);
        tick_seen = 0;
        for (int i = 0; i < 12; i++) cycle("run3", 0, 0, 0, 16'd0, 0);
        chk("ticks_div3", tick_seen, 3);
        chk("running_div3", {31'd0, running}, 1);

        // Hold a new divide value until accepted at the next tick.
        guard = 0;
        last_accept = 0;
        while (!last_accept && guard < 10) begin
            cycle("hold_div1", 0, 0, 1, 16'd1, 0);
            guard++;
        end
        chk("div_accept_cycles", guard, 4);
        tick_seen = 0;
        for (int i = 0; i < 8; i++) cycle("run1", 0, 0, 0, 16'd0, 0);
        chk("ticks_div1", tick_seen, 4);

        // Upset replica 2 of cnt for one cycle.
        cycle("corrupt", 0, 0, 0, 16'd0, 1);
        chk_rep = 1;
        for (int i = 0; i < 4; i++) cycle("post_corrupt", 0, 0, 0, 16'd0, 0);

        // Stop in a tick cycle, then restart with the retained divide value.
        guard = 0;
        while (!(m_run && m_cnt == m_div) && guard < 10) begin
            cycle("to_tick", 0, 0, 0, 16'd0, 0);
            guard++;
        end
        cycle("stop_in_tick", 0, 1, 0, 16'd0, 0);
        cycle("idle_after_stop", 0, 0, 0, 16'd0, 0);
        cycle("restart", 1, 0, 0, 16'd0, 0);
        tick_seen = 0;
        for (int i = 0; i < 6; i++) cycle("run_restart", 0, 0, 0, 16'd0, 0);
        chk("ticks_restart", tick_seen, 3);

        // div_value = 0: tick and div_ready every RUN cycle.
        cycle("stop2", 0, 1, 0, 16'd0, 0);
        cycle("load0", 0, 0, 1, 16'd0, 0);
        cycle("start0", 1, 0, 0, 16'd0, 0);
        tick_seen = 0;
        for (int i = 0; i < 5; i++) cycle("run0", 0, 0, 0, 16'd0, 0);
        chk("ticks_div0", tick_seen, 5);

        // Reset mid-period.
        cycle("stop3", 0, 1, 0, 16'd0, 0);
        cycle("load3b", 0, 0, 1, 16'd3, 0);
        cycle("start3b", 1, 0, 0, 16'd0, 0);
        cycle("mid1", 0, 0, 0, 16'd0, 0);
        cycle("mid2", 0, 0, 0, 16'd0, 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        m_reset();
        push_exp(1'b0);
        check_outputs("mid_reset");
        chk("mid_reset_cnt0", {16'd0, dut.cnt_q0}, 0);
        chk("mid_reset_cnt1", {16'd0, dut.cnt_q1}, 0);
        chk("mid_reset_cnt2", {16'd0, dut.cnt_q2}, 0);
        @(negedge clk);
        rst = 1'b1;
        tick_seen = 0;
        for (int i = 0; i < 8; i++) cycle("after_reset", 0, 0, 0, 16'd0, 0);
        chk("ticks_after_reset", tick_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
